shuffled_card_deck: RTL and testbench



---
 rtl/poker_types.sv | 14 +
 rtl/shuffled_card_deck_lfsr16.sv | 12 +
 rtl/shuffled_card_deck.sv | 74 +++++++
 tb/tb_shuffled_card_deck.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/poker_types.sv
// poker_types: card encoding, deck size and deck controller states shared across the poker datapath
package poker_types;
   typedef enum logic [3:0] {
      TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT, NINE, TEN, JACK, QUEEN, KING, ACE
   } rank_t;
   typedef enum logic [1:0] {CLUBS, DIAMONDS, HEARTS, SPADES} suit_t;
   typedef struct packed {
      rank_t rank;
      suit_t suit;
   } card_t;
   typedef enum logic [1:0] {IDLE, LOAD, SHUFFLE, READY} deck_state_t;
   localparam int DECK_SIZE = 52;
   localparam card_t RESET_CARD = '{rank: ACE, suit: SPADES};
endpackage

// File: rtl/shuffled_card_deck_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting right
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] value
);
   always_ff @(posedge clk or posedge reset)
      if (reset) value <= SEED;
      else value <= {value[0] ^ value[2] ^ value[3] ^ value[5], value[15:1]};
endmodule

// File: rtl/shuffled_card_deck.sv
// shuffled_card_deck: 52-card deck with in-place Fisher-Yates shuffle and sequential draw
module shuffled_card_deck
   import poker_types::*;
#(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_shuffle,
   input  logic       draw_card,
   output card_t      top_card,
   output logic       ready,
   output logic       empty,
   output logic [5:0] cards_left
);
   deck_state_t state, state_nx;
   card_t deck [DECK_SIZE];
   logic [5:0] ptr, idx, j;
   logic [15:0] lfsr;
   logic accept;

   function automatic card_t ordered(int k);
      return '{rank: rank_t'(4'(k % 13)), suit: suit_t'(2'(k / 13))};
   endfunction

   // smallest all-ones value covering v, so the masked candidate is near-uniform before rejection
   function automatic logic [5:0] mask(logic [5:0] v);
      logic [5:0] m;
      m = v | (v >> 1);
      m = m | (m >> 2);
      return m | (m >> 4);
   endfunction

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .reset(reset), .value(lfsr));

   assign j = lfsr[5:0] & mask(idx);
   assign accept = j <= idx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = start_shuffle ? LOAD : IDLE;
         LOAD:    state_nx = start_shuffle ? LOAD : SHUFFLE;
         SHUFFLE: state_nx = start_shuffle ? LOAD : (accept && idx == 6'd1) ? READY : SHUFFLE;
         READY:   state_nx = start_shuffle ? LOAD : READY;
         default: state_nx = IDLE;
      endcase
      ready = state == READY;
      empty = ready && ptr == 6'd52;
      cards_left = ready ? 6'd52 - ptr : 6'd0;
      top_card = (ready && !empty) ? deck[ptr] : RESET_CARD;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         ptr <= '0;
         idx <= 6'd51;
         for (int k = 0; k < DECK_SIZE; k++) deck[k] <= ordered(k);
      end else begin
         state <= state_nx;
         if (state == LOAD) begin
            ptr <= '0;
            idx <= 6'd51;
            for (int k = 0; k < DECK_SIZE; k++) deck[k] <= ordered(k);
         end else if (state == SHUFFLE && !start_shuffle && accept) begin
            deck[idx] <= deck[j];
            deck[j] <= deck[idx];
            idx <= idx - 6'd1;
         end else if (state == READY && !start_shuffle && draw_card && ptr != 6'd52) begin
            ptr <= ptr + 6'd1;
         end
      end
endmodule

// File: tb/tb_shuffled_card_deck.sv
// tb_shuffled_card_deck: directed checks against a reference LFSR / rejection-sampling shuffle model
module tb_shuffled_card_deck;
   import poker_types::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_shuffle = 1'b0;
   logic draw_card = 1'b0;
   card_t top_card;
   logic ready, empty;
   logic [5:0] cards_left;
   int errors = 0;
   int checks = 0;
   logic [15:0] m_lfsr;
   logic [63:0] seen;
   int mdeck [52];
   int exp_cycles;

   shuffled_card_deck #(.LFSR_SEED(16'hACE1)) dut (
      .clk(clk), .reset(reset), .start_shuffle(start_shuffle), .draw_card(draw_card),
      .top_card(top_card), .ready(ready), .empty(empty), .cards_left(cards_left)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(logic [15:0] v);
      logic [15:0] b;
      b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'd1;
      return (v >> 1) | (b << 15);
   endfunction

   always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : lfsr_step(m_lfsr);

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_shuffle(input logic [15:0] v0);
      logic [15:0] v;
      int idx, m, j, t;
      v = v0;
      idx = 51;
      for (int k = 0; k < 52; k++) mdeck[k] = (k % 13) * 4 + k / 13;
      exp_cycles = 0;
      while (idx >= 1) begin
         m = 1;
         while (m < idx) m = m * 2 + 1;
         j = int'(v[5:0]) & m;
         exp_cycles++;
         if (j <= idx) begin
            t = mdeck[idx];
            mdeck[idx] = mdeck[j];
            mdeck[j] = t;
            idx--;
         end
         v = lfsr_step(v);
      end
   endtask

   task automatic run_shuffle(input int hold, input logic with_draw);
      int n;
      n = 0;
      start_shuffle = 1'b1;
      draw_card = with_draw;
      @(negedge clk);
      draw_card = 1'b0;
      check("ready_drop", int'(ready), 0);
      check("left_drop", int'(cards_left), 0);
      repeat (hold - 1) @(negedge clk);
      start_shuffle = 1'b0;
      @(negedge clk);
      model_shuffle(m_lfsr);
      while (!ready && n < 2000) begin
         draw_card = n < 5;
         @(negedge clk);
         n++;
         if (n == 5 && !ready) begin
            check("shuf_top", int'(top_card), 51);
            check("shuf_left", int'(cards_left), 0);
         end
      end
      draw_card = 1'b0;
      check("ready_lat", n, exp_cycles);
      check("min_lat", int'(n >= 51), 1);
   endtask

   task automatic draw_n(input int cnt, input int first);
      for (int i = 0; i < cnt; i++) begin
         check("draw_top", int'(top_card), mdeck[first + i]);
         check("draw_left", int'(cards_left), 52 - first - i);
         seen[int'(top_card)] = 1'b1;
         draw_card = 1'b1;
         @(negedge clk);
         draw_card = 1'b0;
      end
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", int'(ready), 0);
      check("rst_empty", int'(empty), 0);
      check("rst_left", int'(cards_left), 0);
      check("rst_top", int'(top_card), 51);
      draw_card = 1'b1;
      repeat (3) @(negedge clk);
      draw_card = 1'b0;
      check("idle_draw_ready", int'(ready), 0);
      check("idle_draw_top", int'(top_card), 51);
      check("idle_draw_left", int'(cards_left), 0);

      run_shuffle(2, 1'b0);
      seen = '0;
      draw_n(52, 0);
      n = 0;
      for (int c = 0; c < 64; c++) if (seen[c] && (c >> 2) < 13) n++;
      check("distinct", n, 52);
      check("empty_set", int'(empty), 1);
      check("empty_left", int'(cards_left), 0);
      check("empty_top", int'(top_card), 51);
      draw_card = 1'b1;
      repeat (2) @(negedge clk);
      draw_card = 1'b0;
      check("post_empty", int'(empty), 1);
      check("post_left", int'(cards_left), 0);
      check("post_top", int'(top_card), 51);

      run_shuffle(1, 1'b0);
      draw_n(12, 0);
      check("left40", int'(cards_left), 40);
      run_shuffle(1, 1'b1);
      check("reshuf_left", int'(cards_left), 52);
      draw_n(3, 0);

      start_shuffle = 1'b1;
      @(negedge clk);
      start_shuffle = 1'b0;
      repeat (20) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_shuf_ready", int'(ready), 0);
      check("arst_shuf_left", int'(cards_left), 0);
      check("arst_shuf_top", int'(top_card), 51);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("arst_idle_ready", int'(ready), 0);
      run_shuffle(1, 1'b0);
      draw_n(5, 0);

      #2 reset = 1'b1;
      #1;
      check("arst_rdy_ready", int'(ready), 0);
      check("arst_rdy_left", int'(cards_left), 0);
      check("arst_rdy_empty", int'(empty), 0);
      check("arst_rdy_top", int'(top_card), 51);
      @(negedge clk);
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
